box_plotter: RTL and testbench
==============================

# box_plotter

Pixel-stream generator downstream of the x/y screen counters: on a start request it walks a BOX_W x BOX_H rectangle anchored at (x0, y0) in row-major order and emits one VGA-adapter write (x, y, colour, plot) per clock. Used to draw and erase mole and hole sprites on the 160x120, 3-bit-colour frame buffer. Draws a 1-pixel border in one colour and the interior in another, and clips to the screen edges.

## Interface
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are not plotted
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are not plotted
- BOX_W, 16, rectangle width in pixels (>= 2)
- BOX_H, 16, rectangle height in pixels (>= 2)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- x0  in  8  top-left x, latched on accept
- y0  in  7  top-left y, latched on accept
- fill  in  3  interior colour, latched on accept
- border  in  3  border colour, latched on accept
- erase  in  1  latched on accept; 1 forces all pixels to colour 0
- busy  out  1  high while in DRAW
- done  out  1  one-cycle pulse after the last pixel
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  write enable to VGA adapter

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: start=1 at a rising edge latches x0, y0, fill, border, erase; clears dx and dy; goes to DRAW. start=0 stays in IDLE.
- DRAW: each cycle presents the pixel at (dx, dy).
  - dx increments every cycle.
  - When dx = BOX_W-1, dx wraps to 0 and dy increments.
  - When dx = BOX_W-1 and dy = BOX_H-1, the next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE and DRAW. It is not queued.
- Pixel address: px = x0 + dx computed 9-bit; py = y0 + dy computed 8-bit. No wrap-around.
- Clipping: if px >= SCREEN_W or py >= SCREEN_H, then plot=0 for that cycle. The cycle is still consumed, so the total duration is independent of position.
- Colour:
  - erase=1: 0.
  - Otherwise border if dx=0, dx=BOX_W-1, dy=0 or dy=BOX_H-1.
  - Otherwise fill.
- When plot=0 (any state, or a clipped pixel), x, y and colour are driven 0.
- Counter widths: clog2(BOX_W), clog2(BOX_H).

## Timing
- Reset (asynchronous, immediate, any state): state IDLE, dx=dy=0; busy=0, done=0, x=0, y=0, colour=0, plot=0. Latched operands are cleared.
- Reset mid-DRAW aborts the operation. No done pulse is produced. The first edge after release is treated as IDLE.
- Accepting edge N: DRAW is entered after edge N.
- Pixel k (k = dy*BOX_W + dx): presented in the cycle after edge N+k. Outputs are registered or decoded from registered state only; there is no combinational path from start.
- busy: high for exactly BOX_W*BOX_H cycles.
- done: high in the cycle after edge N+BOX_W*BOX_H, with busy=0 and plot=0.
- Back-to-back with start held high: the DONE cycle and one IDLE cycle pass, so the minimum gap is 2 non-busy cycles between operations.
- Latched operands are stable for the whole operation. Input changes during DRAW have no effect.

## Test plan
- Reset: assert resetn=0 with random inputs -> all outputs 0. Release, hold start=0 for 20 cycles -> busy=0, plot=0 throughout.
- Basic draw: x0=10, y0=20, fill=3'b010, border=3'b111 -> 256 busy cycles and 256 plot pulses.
  - First pixel (10,20,7); (11,21) colour 2; (24,34) colour 2; (25,20) colour 7; last (25,35,7).
  - Then a single done pulse.
- Clipping: x0=150, y0=110 -> 256 busy cycles, exactly 100 plot pulses (dx,dy < 10). No plotted x >= 160 or y >= 120; done after 256 cycles.
- Erase: x0=40, y0=40, erase=1, fill=5, border=6 -> 256 plot pulses, all colour 0.
- Start handling:
  - Pulse start again at pixel 100 with x0=0 -> ignored, no coordinate change.
  - Hold start=1 continuously -> second operation begins with exactly 2 busy-low cycles between, the first of them with done=1.
- Reset mid-draw: drop resetn at pixel 50 -> outputs 0 within the same cycle, no done pulse. After release, start with x0=0, y0=0 -> normal 256-pixel draw from (0,0).

Source files
------------

// File: rtl/box_plotter.sv
// box_plotter: walks a BOX_W x BOX_H rectangle at (x0, y0) emitting one clipped VGA pixel write per clock.
//   clock, resetn        : clock (rising edge) and asynchronous active-low reset
//   start                : draw request, sampled only while idle
//   x0, y0, fill, border : anchor and colours, latched when the request is accepted
//   erase                : latched on accept; forces every pixel to colour 0
//   busy, done           : high while drawing / one-cycle pulse after the last pixel
//   x, y, colour, plot   : pixel write to the VGA adapter, all zero when plot is low
module box_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int BOX_W    = 16,
    parameter int BOX_H    = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [2:0] fill,
    input  logic [2:0] border,
    input  logic       erase,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);
    localparam int DXW = $clog2(BOX_W);
    localparam int DYW = $clog2(BOX_H);
    localparam logic [DXW-1:0] DX_LAST = DXW'(BOX_W - 1);
    localparam logic [DYW-1:0] DY_LAST = DYW'(BOX_H - 1);
    localparam logic [8:0] SW = 9'(SCREEN_W);
    localparam logic [7:0] SH = 8'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t         state_q;
    logic [DXW-1:0] dx_q;
    logic [DYW-1:0] dy_q;
    logic [7:0]     x0_q;
    logic [6:0]     y0_q;
    logic [2:0]     fill_q;
    logic [2:0]     border_q;
    logic           erase_q;
    logic           busy_q;
    logic           done_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            dx_q     <= '0;
            dy_q     <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            fill_q   <= '0;
            border_q <= '0;
            erase_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    x0_q     <= x0;
                    y0_q     <= y0;
                    fill_q   <= fill;
                    border_q <= border;
                    erase_q  <= erase;
                    dx_q     <= '0;
                    dy_q     <= '0;
                    busy_q   <= 1'b1;
                    state_q  <= DRAW;
                end
                DRAW: if (dx_q == DX_LAST) begin
                    dx_q <= '0;
                    dy_q <= dy_q + 1'b1;
                    if (dy_q == DY_LAST) begin
                        dy_q    <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end else begin
                    dx_q <= dx_q + 1'b1;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pixel address is widened so anchors near the edge clip instead of wrapping.
    logic [8:0] px;
    logic [7:0] py;
    logic       on_edge;

    always_comb begin
        px      = {1'b0, x0_q} + 9'(dx_q);
        py      = {1'b0, y0_q} + 8'(dy_q);
        on_edge = dx_q == '0 || dx_q == DX_LAST || dy_q == '0 || dy_q == DY_LAST;
        plot    = busy_q && px < SW && py < SH;
        x       = plot ? px[7:0] : 8'd0;
        y       = plot ? py[6:0] : 7'd0;
        colour  = !plot || erase_q ? 3'd0 : on_edge ? border_q : fill_q;
    end

    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_box_plotter.sv
// tb_box_plotter: randomized and directed checks of box_plotter against a pixel-rule reference model.
module tb_box_plotter;
    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] fill;
    logic [2:0] border;
    logic       erase;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int checks = 0;
    int failures = 0;

    box_plotter dut (
        .clock(clock), .resetn(resetn), .start(start), .x0(x0), .y0(y0),
        .fill(fill), .border(border), .erase(erase), .busy(busy), .done(done),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, exp_done);
        chk({tag, " plot"}, plot, 0);
        chk({tag, " x"}, x, 0);
        chk({tag, " y"}, y, 0);
        chk({tag, " colour"}, colour, 0);
    endtask

    task automatic scramble();
        x0 = 8'($urandom); y0 = 7'($urandom); fill = 3'($urandom);
        border = 3'($urandom); erase = 1'($urandom);
    endtask

    task automatic start_op(input int ax, input int ay, input int af, input int ab, input int ae);
        @(negedge clock);
        chk("pre-start busy", busy, 0);
        x0 = 8'(ax); y0 = 7'(ay); fill = 3'(af); border = 3'(ab); erase = 1'(ae);
        start = 1'b1;
    endtask

    // mode: 0 plain, 1 hold start high, 2 poke start with x0=0 at pixel 100, 3 random input noise
    task automatic draw(input int ax, input int ay, input int af, input int ab, input int ae,
                        input int mode, input int exp_plots);
        int plots = 0;
        for (int k = 0; k < 256; k++) begin
            int dx, dy, px, py, ep, ec;
            @(negedge clock);
            dx = k % 16; dy = k / 16; px = ax + dx; py = ay + dy;
            ep = (px < 160 && py < 120) ? 1 : 0;
            ec = (!ep || ae != 0) ? 0 : (dx == 0 || dx == 15 || dy == 0 || dy == 15) ? ab : af;
            chk($sformatf("pix%0d busy", k), busy, 1);
            chk($sformatf("pix%0d done", k), done, 0);
            chk($sformatf("pix%0d plot", k), plot, ep);
            chk($sformatf("pix%0d x", k), x, ep ? px : 0);
            chk($sformatf("pix%0d y", k), y, ep ? py : 0);
            chk($sformatf("pix%0d colour", k), colour, ec);
            plots += int'(plot === 1'b1);
            if (mode == 0) start = 1'b0;
            if (mode == 2) begin start = (k == 100); if (k == 100) x0 = 8'd0; end
            if (mode == 3) begin start = 1'($urandom); scramble(); end
        end
        @(negedge clock);
        chk_idle("done cycle", 1);
        if (exp_plots >= 0) chk("plot count", plots, exp_plots);
        if (mode != 1) start = 1'b0;
        @(negedge clock);
        chk_idle("idle cycle", 0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'($urandom); scramble();
        #1;
        chk_idle("reset", 0);
        @(negedge clock);
        chk_idle("reset held", 0);
        resetn = 1'b1; start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle busy", busy, 0);
            chk("idle plot", plot, 0);
        end

        start_op(10, 20, 3'b010, 3'b111, 0);
        draw(10, 20, 3'b010, 3'b111, 0, 0, 256);

        start_op(150, 110, 1, 4, 0);
        draw(150, 110, 1, 4, 0, 0, 100);

        start_op(40, 40, 5, 6, 1);
        draw(40, 40, 5, 6, 1, 0, 256);

        start_op(60, 30, 3, 1, 0);
        draw(60, 30, 3, 1, 0, 2, 256);

        // Held start: DONE cycle then one IDLE cycle, then the next operation.
        start_op(70, 50, 4, 2, 0);
        draw(70, 50, 4, 2, 0, 1, 256);
        draw(70, 50, 4, 2, 0, 0, 256);

        for (int r = 0; r < 6; r++) begin
            int ax = int'($urandom_range(0, 255));
            int ay = int'($urandom_range(0, 127));
            int af = int'($urandom_range(0, 7));
            int ab = int'($urandom_range(0, 7));
            int ae = int'($urandom_range(0, 1));
            start_op(ax, ay, af, ab, ae);
            draw(ax, ay, af, ab, ae, 3, -1);
        end

        // Reset in the middle of a draw.
        start_op(20, 20, 2, 5, 0);
        for (int k = 0; k <= 50; k++) begin
            @(negedge clock);
            start = 1'b0;
        end
        chk("pre-abort busy", busy, 1);
        resetn = 1'b0;
        #1;
        chk_idle("abort", 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_idle("abort held", 0);
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_idle("after abort", 0);
        end
        start_op(0, 0, 6, 3, 0);
        draw(0, 0, 6, 3, 0, 0, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
